// File: rtl/dftobserve_tdo_chain_pkg.sv
// Shared types and defaults for the stepdown/powergood observe chain.
package dft_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } dft_state_e;

    localparam int DFT_SYNC_STAGES_DEF = 2;
    localparam int DFT_WIDTH_DEF       = 8;

endpackage

// File: rtl/dftobserve_tdo_chain_sync.sv
// Multi-stage synchroniser for one observation bit crossing into the tck domain.
module dft_sync_bit
    import dft_pkg::*;
#(
    parameter int STAGES = DFT_SYNC_STAGES_DEF
) (
    input  logic tck,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/dftobserve_tdo_chain.sv
// Observe-side scan cell chain: captures synchronised status points and shifts them out on tdo.
//  state  | meaning
//  IDLE   | no frame loaded; tdo carries the 1-bit bypass flop
//  LOADED | shadow holds a fresh capture, no shift yet
//  SHIFT  | frame partially shifted out
//  DONE   | all WIDTH bits shifted; shadow acts as a WIDTH-deep delay line
module dftobserve_tdo_chain
    import dft_pkg::*;
#(
    parameter int WIDTH       = DFT_WIDTH_DEF,
    parameter int SYNC_STAGES = DFT_SYNC_STAGES_DEF
) (
    input  logic             tck,
    input  logic             rst,
    input  logic             ten,
    input  logic             cap,
    input  logic             shf,
    input  logic             tdi_chain,
    input  logic [WIDTH-1:0] obs,
    output logic             tdo,
    output logic             frame_done,
    input  logic             CELG,
    input  logic             CELSUB,
    input  logic             CELV
);

    localparam int              CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(WIDTH);

    dft_state_e       state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bypass_q, bypass_d;
    logic             frame_done_q, frame_done_d;

    logic [WIDTH-1:0] obs_s;
    logic [WIDTH-1:0] shadow_shift;
    logic [CW-1:0]    cnt_inc;

    // Supplies exist only so the netlist matches the layout for LVS.
    logic unused_supply;
    assign unused_supply = CELG ^ CELSUB ^ CELV;

    for (genvar i = 0; i < WIDTH; i++) begin : g_sync
        dft_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
            .tck (tck),
            .rst (rst),
            .d   (obs[i]),
            .q   (obs_s[i])
        );
    end

    if (WIDTH == 1) begin : g_shift_one
        assign shadow_shift = tdi_chain;
    end else begin : g_shift_multi
        assign shadow_shift = {tdi_chain, shadow_q[WIDTH-1:1]};
    end

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        cnt_d        = cnt_q;
        bypass_d     = bypass_q;
        frame_done_d = 1'b0;
        if (!ten) begin
            state_d = IDLE;
        end else if (cap) begin
            shadow_d = obs_s;
            cnt_d    = '0;
            state_d  = LOADED;
        end else if (shf) begin
            case (state_q)
                IDLE: begin
                    bypass_d = tdi_chain;
                end
                LOADED, SHIFT: begin
                    shadow_d = shadow_shift;
                    cnt_d    = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        state_d      = DONE;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
                DONE: begin
                    shadow_d = shadow_shift;
                    cnt_d    = CNT_MAX;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            cnt_q        <= '0;
            bypass_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            cnt_q        <= cnt_d;
            bypass_q     <= bypass_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Only the ten gate is combinational; tdi_chain always reaches tdo through a flop.
    assign tdo        = ten & ((state_q == IDLE) ? bypass_q : shadow_q[0]);
    assign frame_done = frame_done_q;

endmodule
